fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//   Downstream consumer of the show-ahead byte FIFO: pops one word whenever the FIFO
//   reports valid data and the line is free, then serialises it as an asynchronous
//   UART frame (start, data LSB-first, optional parity, stop) on a single TX pin.
//   Sits between the FIFO read port and the chip pad; the FIFO absorbs bursts,
//   and this block paces them out at the programmed bit rate.
// PARAMETERS
//   DATA_WIDTH    8   width of FIFO word / UART data field
//   CLKS_PER_BIT  16  clk cycles per UART bit (>=2)
//   PARITY_EN     0   1 = insert parity bit after data
//   PARITY_ODD    0   1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//   STOP_BITS     1   number of stop bits (1 or 2)
// PORTS
//   clk        in   1           system clock, all state on rising edge
//   reset      in   1           synchronous, active-high
//   enable     in   1           1 = allowed to start new frames
//   fifo_val   in   1           FIFO holds data; fifo_data is valid
//   fifo_data  in   DATA_WIDTH  FIFO head word (show-ahead, combinational)
//   fifo_read  out  1           pop strobe; one cycle per word consumed
//   tx         out  1           serial line, idle high
//   busy       out  1           frame in progress (START..STOP)
// BEHAVIOUR
//   - Reset: state=IDLE, tx=1, busy=0, fifo_read=0, bit/baud counters=0, shift reg=0.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   - Pop rule: fifo_read = (state==IDLE | last cycle of final STOP bit) & enable &
//     fifo_val & ~reset. Combinational; fifo_data latched into shift reg on that edge.
//     Never asserted when fifo_val=0; exactly one pulse per word.
//   - Latency: tx drops to 0 on the clock edge that pops the word (registered tx, so
//     visible the cycle after fifo_read=1). busy rises at the same edge.
//   - Each bit is held exactly CLKS_PER_BIT cycles; baud counter restarts at every
//     bit boundary, no drift accumulates across frames.
//   - DATA: bit 0 first; bit counter 0..DATA_WIDTH-1, width $clog2(DATA_WIDTH)+1.
//   - PARITY: XOR of the captured word, inverted when PARITY_ODD=1.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. If a pop occurs in its final cycle,
//     next state is START (back-to-back, zero idle gap); else IDLE, busy falls.
//   - Frame length = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//   - enable dropped mid-frame: current frame completes; no new pop until enable=1.
//   - fifo_val dropped mid-frame: irrelevant; word already captured.
//   - reset mid-frame: next edge returns to reset state, tx=1 immediately; word lost,
//     no pop in the reset cycle.
//   - Words not popped are left in the FIFO untouched; block never reads FIFO when full
//     line is busy, so FIFO full is the only upstream backpressure.
// STRUCTURE
//   - Shared package uart_pkg: state encoding localparams (IDLE,START,DATA,PARITY,
//     STOP), frame-length helper function, LINE_IDLE=1'b1 constant.
//   - Sub-module uart_baud_gen: CLKS_PER_BIT down-counter with restart input and
//     bit_done pulse; reused later by the receiver.
//   - Top: FSM, shift register, bit counter, stop-bit counter, parity register.
// TESTING  (DATA_WIDTH=8, CLKS_PER_BIT=4 unless noted)
//   1 reset held, fifo_val=1 -> fifo_read=0, tx=1, busy=0 throughout.
//   2 single word 8'hA5, enable=1 -> one fifo_read pulse; tx = 0,1,0,1,0,0,1,0,1,1
//     each 4 cycles; busy high 40 cycles then low.
//   3 three words 8'h01,8'hFF,8'h00 queued -> 3 pops, frames back-to-back, tx never
//     idle between stop and next start; total 120 cycles.
//   4 PARITY_EN=1, PARITY_ODD=1, word 8'h03 -> parity bit=1; 8'h07 -> parity bit=0;
//     frame 44 cycles. STOP_BITS=2 -> 48 cycles.
//   5 reset asserted at cycle 15 of a frame for 8'h55 -> tx=1, busy=0 next cycle;
//     after release with fifo_val=1, fresh frame starts with next FIFO word.
//   6 enable=0 with fifo_val=1 -> no pop, tx=1; deassert enable mid-frame -> frame
//     finishes, no second pop until enable=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Provides the frame state encoding,
//                the idle line level and a helper that returns the length of
//                one frame in clk cycles. Used by the transmitter and, later,
//                the receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Frame state encoding
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_START  = START,
        ST_DATA   = DATA,
        ST_PARITY = PARITY,
        ST_STOP   = STOP
    } uart_state_e;

    // A UART line rests at mark (logic 1)
    localparam logic LINE_IDLE = 1'b1;

    // Number of clk cycles in one complete frame
    function automatic int unsigned frame_cycles(input int unsigned data_width,
                                                 input int unsigned clks_per_bit,
                                                 input int unsigned parity_en,
                                                 input int unsigned stop_bits);
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period timer. Down-counts CLKS_PER_BIT cycles per bit and
//                pulses bit_done in the last cycle of every bit. restart
//                re-aligns the period to the current edge; while inactive the
//                counter rests at zero.
//  Ports       : clk      in  system clock
//                reset    in  synchronous, active-high
//                restart  in  load a full bit period on this edge
//                active   in  a frame is in progress
//                bit_done out last cycle of the current bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic active,
    output logic bit_done
);

    localparam int              CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reloading at every bit boundary keeps each bit exactly CLKS_PER_BIT
    // cycles long, so no phase error carries from one bit or frame to the next.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = RELOAD;
        end else if (!active) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = active & (cnt_q == '0);

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Pops words from a show-ahead FIFO and serialises each one as
//                an asynchronous UART frame: start, data LSB first, optional
//                parity, one or two stop bits. Back-to-back frames have no
//                idle gap when the FIFO keeps data available.
//  Ports       : clk       in  system clock
//                reset     in  synchronous, active-high
//                enable    in  permits starting new frames
//                fifo_val  in  FIFO head word is valid
//                fifo_data in  FIFO head word
//                fifo_read out pop strobe, one cycle per word
//                tx        out serial line, idle high
//                busy      out frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_val,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    uart_state_e           state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  parity_q,   parity_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q,     busy_d;

    logic bit_done;
    logic last_stop;
    logic pop;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (pop),
        .active   (state_q != ST_IDLE),
        .bit_done (bit_done)
    );

    // Final cycle of the final stop bit: the line may be handed straight to
    // the next start bit here.
    assign last_stop = (state_q == ST_STOP) & bit_done &
                       (stop_cnt_q == 1'(STOP_BITS - 1));

    assign pop       = ((state_q == ST_IDLE) | last_stop) & enable & fifo_val & ~reset;
    assign fifo_read = pop;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = LINE_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = LINE_IDLE;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase

        // A pop overrides whatever the frame logic chose: capture the word
        // and drive the start bit on this same edge.
        if (pop) begin
            state_d    = ST_START;
            shift_d    = fifo_data;
            parity_d   = (^fifo_data) ^ (PARITY_ODD != 0);
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule : fifo_uart_tx
`default_nettype wire
